// File: rtl/ser_pkg.sv
// Shared definitions for the serial word link (transmitter and receiver):
// FSM encoding, counter-width helper and the framing constants of the link.
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_WORD_MIN = 2;
  localparam int SER_WORD_MAX = 32;

  // Link framing: words travel MSB first, bit 0 is flagged by a high marker.
  localparam bit SER_MSB_FIRST = 1'b1;
  localparam bit SER_LSB_MARK  = 1'b1;

  function automatic int ser_cnt_w(input int word_size);
    return (word_size < 2) ? 1 : $clog2(word_size);
  endfunction

endpackage

// File: rtl/par2ser_hold.sv
// One-word holding register for par2ser, used only when PAR2SER_HOLD_EN is defined.
module par2ser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             hold_valid_o,
  output logic [WIDTH-1:0] hold_data_o
);

  logic             hold_valid_q;
  logic [WIDTH-1:0] hold_data_q;

  // Write and read never coincide: a write needs an empty slot, a read a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
    end else if (wr_en_i) begin
      hold_valid_q <= 1'b1;
    end else if (rd_en_i) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      hold_data_q <= wr_data_i;
    end
  end

  assign hold_valid_o = hold_valid_q;
  assign hold_data_o  = hold_data_q;

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial transmitter: MSB-first shifter with lsb_out framing marker.
// Define PAR2SER_HOLD_EN to add a one-word holding register in front of the shifter.
module par2ser
  import ser_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] par_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 serial_out,
  output logic                 lsb_out,
  output logic                 busy
);

  localparam int              CW      = ser_cnt_w(WORD_SIZE);
  localparam logic [CW-1:0]   CNT_TOP = CW'(WORD_SIZE - 1);

  if (WORD_SIZE < SER_WORD_MIN || WORD_SIZE > SER_WORD_MAX || !SER_MSB_FIRST) begin : g_bad_cfg
    $error("par2ser: WORD_SIZE must lie in 2..32");
  end

  ser_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic                 lsb_q, lsb_d;
  logic                 busy_q, busy_d;

  logic                 last_bit;
  logic                 shifter_free;
  logic                 load;
  logic [WORD_SIZE-1:0] load_data;

  assign last_bit     = (state_q == S_SHIFT) && (cnt_q == '0);
  assign shifter_free = (state_q == S_IDLE) || last_bit;

`ifdef PAR2SER_HOLD_EN
  logic                 accept;
  logic                 hold_valid;
  logic [WORD_SIZE-1:0] hold_data;

  assign in_ready  = !reset && !hold_valid;
  assign accept    = in_valid && in_ready;
  // A held word always goes first; a fresh word can only arrive while the slot is empty.
  assign load      = shifter_free && (hold_valid || accept);
  assign load_data = hold_valid ? hold_data : par_in;

  par2ser_hold #(
    .WIDTH(WORD_SIZE)
  ) u_hold (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (accept && !shifter_free),
    .wr_data_i    (par_in),
    .rd_en_i      (shifter_free && hold_valid),
    .hold_valid_o (hold_valid),
    .hold_data_o  (hold_data)
  );
`else
  assign in_ready  = !reset && shifter_free;
  assign load      = in_valid && in_ready;
  assign load_data = par_in;
`endif

  // Next state: loading wins over the idle return, which keeps back-to-back words gap-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    lsb_d   = ~SER_LSB_MARK;
    busy_d  = busy_q;
    if (load) begin
      state_d = S_SHIFT;
      cnt_d   = CNT_TOP;
      shreg_d = load_data;
      busy_d  = 1'b1;
    end else if (state_q == S_SHIFT) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        shreg_d = '0;
        busy_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q - CW'(1);
        shreg_d = shreg_q << 1;
        lsb_d   = (cnt_q == CW'(1)) ? SER_LSB_MARK : ~SER_LSB_MARK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      lsb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      lsb_q   <= lsb_d;
      busy_q  <= busy_d;
    end
  end

  // The shifter MSB is the line bit; it is cleared whenever the FSM is idle.
  assign serial_out = shreg_q[WORD_SIZE-1];
  assign lsb_out    = lsb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_par2ser.sv
// Testbench for par2ser: directed and random words checked cycle by cycle against
// a schedule model, plus a framing receiver that rebuilds words from the serial line.
module tb_par2ser;

  localparam int W  = 8;
  localparam int NC = 8192;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] par_in;
  logic         in_valid;
  logic         in_ready;
  logic         serial_out;
  logic         lsb_out;
  logic         busy;

  always #5 clk = ~clk;

  par2ser #(
    .WORD_SIZE(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .par_in     (par_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .lsb_out    (lsb_out),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  // cyc names the clock period that ends with the next rising edge.
  int cyc = 1;

  logic exp_bit  [NC];
  logic exp_lsb  [NC];
  logic exp_busy [NC];

  // Schedule of the most recent word: edge it was accepted, edge it entered
  // the shifter, and the last cycle carrying one of its bits.
  int last_accept = 0;
  int last_start  = 0;
  int last_end    = 0;

  logic [W-1:0] sentq[$];
  logic [W-1:0] rx = '0;
  logic         acc_last = 1'b0;

  function automatic logic model_ready();
`ifdef PAR2SER_HOLD_EN
    return !(last_accept < cyc && last_start >= cyc);
`else
    return last_end <= cyc;
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic rdy;
    int   s;
    if (cyc >= NC - 3 * W) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 3 * W);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk);
    reset    = r;
    in_valid = v;
    par_in   = d;
    #1;
    rdy = r ? 1'b0 : model_ready();
    chk("in_ready", in_ready, rdy);
    chk("serial_out", serial_out, exp_bit[cyc]);
    chk("lsb_out", lsb_out, exp_lsb[cyc]);
    chk("busy", busy, exp_busy[cyc]);
    rx = {rx[W-2:0], serial_out};
    if (lsb_out === 1'b1) begin
      chk("rx_word_expected", logic'(sentq.size() != 0), 1'b1);
      if (sentq.size() != 0) chkw("rx_word", 32'(rx), 32'(sentq.pop_front()));
    end
    acc_last = v && rdy;
    @(posedge clk);
    if (r) begin
      for (int c = cyc + 1; c <= cyc + 2 * W + 2; c++) begin
        exp_bit[c]  = 1'b0;
        exp_lsb[c]  = 1'b0;
        exp_busy[c] = 1'b0;
      end
      last_accept = 0;
      last_start  = 0;
      last_end    = 0;
      sentq.delete();
    end else if (acc_last) begin
      s           = (last_end > cyc) ? last_end : cyc;
      last_accept = cyc;
      last_start  = s;
      last_end    = s + W;
      for (int i = 0; i < W; i++) begin
        exp_bit[s + 1 + i]  = d[W-1-i];
        exp_lsb[s + 1 + i]  = (i == W - 1);
        exp_busy[s + 1 + i] = 1'b1;
      end
      sentq.push_back(d);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
  endtask

  task automatic send(input logic [W-1:0] d);
    int n = 0;
    do begin
      step(1'b1, d, 1'b0);
      n++;
    end while (!acc_last && n < 64);
    chk("accept_timeout", acc_last, 1'b1);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      exp_bit[c]  = 1'b0;
      exp_lsb[c]  = 1'b0;
      exp_busy[c] = 1'b0;
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    par_in   = '0;
    @(posedge clk);
    cyc = 2;
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(2);

    // Single word from idle, then back-to-back pair with in_valid held.
    send(8'hA5);
    idle(W + 2);
    send(8'h3C);
    send(8'hC3);
    idle(W + 2);

    // Word offered two cycles into another word.
    send(8'h96);
    idle(1);
    send(8'h55);
    idle(W + 2);

    // Reset after three bits abandons the word; next word goes out cleanly.
    send(8'hFF);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    idle(2);
    send(8'h01);
    idle(W + 2);

    // Extremes back-to-back, then a continuously offered stream.
    send(8'h00);
    send(8'hFF);
    send(8'h81);
    idle(W + 2);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(2 * W + 2);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        idle($urandom_range(0, 2 * W));
        step(1'b0, W'($urandom), 1'b1);
      end else begin
        idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 3));
        send(W'($urandom));
      end
    end
    idle(2 * W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
